// File: rtl/cal_psum_acc_lrelu.sv
// cal_psum_acc_lrelu: accumulates adder-tree partial sums per output pixel,
// then requantizes with a rounding shift, optional leaky ReLU and int8 saturation.
module cal_psum_acc_lrelu #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [17:0]      din,
    input  logic             din_first,
    input  logic             din_last,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu_en,
    output logic             dout_valid,
    output logic [OUT_W-1:0] dout,
    output logic             sat_flag
);
    localparam logic signed [ACC_W:0] ZMAX = (ACC_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] ZMIN = ~ZMAX;

    logic signed [ACC_W-1:0] acc, sum, s1_sum;
    logic [4:0]              s1_shift;
    logic                    s1_relu, s1_valid, s2_relu, s2_valid, s3_valid;
    logic signed [ACC_W:0]   rnd, y, s2_y, z, s3_z;
    logic signed [ACC_W+5:0] prod;

    assign sum  = (din_first ? '0 : acc) + {{(ACC_W - 18){din[17]}}, din};
    assign rnd  = (s1_shift == 5'd0) ? '0 : (ACC_W + 1)'(1) << (s1_shift - 5'd1);
    assign y    = ($signed({s1_sum[ACC_W-1], s1_sum}) + rnd) >>> s1_shift;
    // slope 13/128 approximates 0.1; the arithmetic shift floors
    assign prod = $signed({{5{s2_y[ACC_W]}}, s2_y}) * (ACC_W + 6)'(13);
    assign z    = (s2_relu && s2_y[ACC_W]) ? (ACC_W + 1)'(prod >>> 7) : s2_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            s1_sum     <= '0;
            s1_shift   <= '0;
            s1_relu    <= 1'b0;
            s1_valid   <= 1'b0;
            s2_y       <= '0;
            s2_relu    <= 1'b0;
            s2_valid   <= 1'b0;
            s3_z       <= '0;
            s3_valid   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            if (din_valid) acc <= din_last ? '0 : sum;
            s1_valid <= din_valid && din_last;
            if (din_valid && din_last) begin
                s1_sum   <= sum;
                s1_shift <= cfg_shift;
                s1_relu  <= cfg_relu_en;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y    <= y;
                s2_relu <= s1_relu;
            end
            s3_valid <= s2_valid;
            if (s2_valid) s3_z <= z;
            dout_valid <= s3_valid;
            if (s3_valid) begin
                dout     <= (s3_z > ZMAX) ? ZMAX[OUT_W-1:0] :
                            (s3_z < ZMIN) ? ZMIN[OUT_W-1:0] : s3_z[OUT_W-1:0];
                sat_flag <= (s3_z > ZMAX) || (s3_z < ZMIN);
            end
        end
    end
endmodule

// File: tb/tb_cal_psum_acc_lrelu.sv
// tb_cal_psum_acc_lrelu: directed and randomized checks of the accumulate /
// requantize stage against an arithmetic reference model.
module tb_cal_psum_acc_lrelu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        din_valid = 1'b0, din_first = 1'b0, din_last = 1'b0, cfg_relu_en = 1'b0;
    logic [17:0] din = '0;
    logic [4:0]  cfg_shift = '0;
    logic        dout_valid, sat_flag;
    logic [7:0]  dout;

    typedef struct packed {
        logic [31:0] c;
        logic [7:0]  d;
        logic        s;
    } out_t;

    int   checks = 0, errors = 0, cyc = 0, m_acc = 0;
    out_t exp_q[$], got_q[$];

    cal_psum_acc_lrelu dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .din_first(din_first), .din_last(din_last), .cfg_shift(cfg_shift),
        .cfg_relu_en(cfg_relu_en), .dout_valid(dout_valid), .dout(dout),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dout_valid) got_q.push_back('{32'(cyc), dout, sat_flag});

    function automatic longint fdiv(input longint a, input longint b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic out_t model(input int s, input int sh, input bit r, input int c);
        longint y, z;
        out_t   o;
        y = (sh == 0) ? longint'(s) : fdiv(longint'(s) + (longint'(1) << (sh - 1)), longint'(1) << sh);
        z = (r && y < 0) ? fdiv(y * 13, 128) : y;
        o.c = 32'(c);
        o.s = (z > 127) || (z < -128);
        o.d = 8'((z > 127) ? 127 : (z < -128) ? -128 : z);
        return o;
    endfunction

    task automatic beat(input int d, input bit f, input bit l, input int sh = 0, input bit r = 0);
        int s;
        @(negedge clk);
        din_valid = 1'b1; din = 18'(d); din_first = f; din_last = l;
        cfg_shift = 5'(sh); cfg_relu_en = r;
        @(posedge clk); #1;
        s = (f ? 0 : m_acc) + d;
        if (l) begin
            exp_q.push_back(model(s, sh, r, cyc + 3));
            m_acc = 0;
        end else m_acc = s;
        din_valid = 1'b0; din = 18'($urandom); din_first = 1'($urandom);
        din_last = 1'($urandom); cfg_shift = 5'($urandom); cfg_relu_en = 1'($urandom);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({dout_valid, dout, sat_flag} !== 10'd0) begin
            errors++; $display("FAIL reset_state got=%b want=0", {dout_valid, dout, sat_flag});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        beat(1000, 1, 1, 3, 0);
        settle();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL single_count got=%0d want=1", got_q.size());
        end else begin
            checks++;
            if ({got_q[0].d, got_q[0].s, got_q[0].c} !== {8'd125, 1'b0, exp_q[0].c}) begin
                errors++; $display("FAIL single got=%0d/%0d@%0d want=125/0@%0d", $signed(got_q[0].d), got_q[0].s, got_q[0].c, exp_q[0].c);
            end
        end
        checks++;
        if ({dout_valid, dout, sat_flag} !== {1'b0, 8'd125, 1'b0}) begin
            errors++; $display("FAIL hold got=%b/%0d/%b want=0/125/0", dout_valid, dout, sat_flag);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_group_idle();
        beat(500, 1, 0, 2);
        repeat (2) @(posedge clk);
        beat(300, 0, 0, 7);
        repeat (3) @(posedge clk);
        beat(-100, 0, 1, 2, 0);
        settle();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL group_count got=%0d want=1", got_q.size());
        end else begin
            checks++;
            if ({got_q[0].d, got_q[0].s, got_q[0].c} !== {8'd127, 1'b1, exp_q[0].c}) begin
                errors++; $display("FAIL group got=%0d/%0d@%0d want=127/1@%0d", $signed(got_q[0].d), got_q[0].s, got_q[0].c, exp_q[0].c);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_relu_restart();
        logic [8:0] want[] = '{{8'hF5, 1'b0}, {8'h9C, 1'b0}, {8'd7, 1'b0}};
        beat(-800, 1, 1, 3, 1);
        beat(-800, 1, 1, 3, 0);
        beat(50, 1, 0);
        beat(7, 1, 1, 0, 0);
        settle();
        checks++;
        if (got_q.size() != want.size()) begin
            errors++; $display("FAIL relu_count got=%0d want=%0d", got_q.size(), want.size());
        end
        foreach (want[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].d, got_q[i].s, got_q[i].c} !== {want[i], exp_q[i].c}) begin
                errors++; $display("FAIL relu[%0d] got=%0d/%0d@%0d want=%0d/%0d@%0d", i, $signed(got_q[i].d), got_q[i].s, got_q[i].c, $signed(want[i][8:1]), want[i][0], exp_q[i].c);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        logic [8:0] want[] = '{{8'h80, 1'b1}, {8'd127, 1'b0}, {8'h80, 1'b0}, {8'd127, 1'b1}, {8'h80, 1'b1}};
        beat(-131072, 1, 1, 0, 0);
        beat(127, 1, 1, 0, 0);
        beat(-128, 1, 1, 0, 0);
        beat(128, 1, 1, 0, 0);
        beat(-129, 1, 1, 0, 0);
        settle();
        checks++;
        if (got_q.size() != want.size()) begin
            errors++; $display("FAIL sat_count got=%0d want=%0d", got_q.size(), want.size());
        end
        foreach (want[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].d, got_q[i].s, got_q[i].c} !== {want[i], exp_q[i].c}) begin
                errors++; $display("FAIL sat[%0d] got=%0d/%0d@%0d want=%0d/%0d@%0d", i, $signed(got_q[i].d), got_q[i].s, got_q[i].c, $signed(want[i][8:1]), want[i][0], exp_q[i].c);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [8:0] want[] = '{{8'd1, 1'b0}, {8'd16, 1'b0}, {8'd3, 1'b0}};
        beat(8, 1, 1, 3);
        beat(16, 1, 1, 0);
        beat(24, 1, 1, 3);
        settle();
        checks++;
        if (got_q.size() != want.size()) begin
            errors++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), want.size());
        end
        foreach (want[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].d, got_q[i].s, got_q[i].c} !== {want[i], exp_q[i].c}) begin
                errors++; $display("FAIL b2b[%0d] got=%0d/%0d@%0d want=%0d/%0d@%0d", i, $signed(got_q[i].d), got_q[i].s, got_q[i].c, want[i][8:1], want[i][0], exp_q[i].c);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        beat(5, 1, 1);
        beat(7, 1, 0);
        beat(9, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_valid, dout, sat_flag} !== 10'd0) begin
            errors++; $display("FAIL reset_mid_outputs got=%b want=0", {dout_valid, dout, sat_flag});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        got_q.delete(); exp_q.delete(); m_acc = 0;
        beat(10, 0, 1, 0, 0);
        settle();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL reset_mid_count got=%0d want=1", got_q.size());
        end else begin
            checks++;
            if ({got_q[0].d, got_q[0].s, got_q[0].c} !== {8'd10, 1'b0, exp_q[0].c}) begin
                errors++; $display("FAIL reset_mid got=%0d/%0d@%0d want=10/0@%0d", $signed(got_q[0].d), got_q[0].s, got_q[0].c, exp_q[0].c);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) @(posedge clk);
            else beat(int'($urandom_range(0, 262143)) - 131072,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 31)),
                      1'($urandom));
        end
        beat(0, 0, 1);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand[%0d] got=%0d/%0d@%0d want=%0d/%0d@%0d", i, $signed(got_q[i].d), got_q[i].s, got_q[i].c, $signed(exp_q[i].d), exp_q[i].s, exp_q[i].c);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_group_idle();
        test_relu_restart();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
